// File: rtl/datapath_pkg.sv
// Shared types for the datapath_core slice: ALU opcodes, PC/operand selects and FSM states.
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_NAND  = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SHL   = 4'd8,
    ALU_SHR   = 4'd9,
    ALU_ASR   = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_t;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_INC    = 3'd1,
    PC_RESULT = 3'd2,
    PC_BUS    = 3'd3,
    PC_LR     = 3'd4
  } pc_sel_t;

  typedef enum logic [1:0] {
    OP2_IMM   = 2'd0,
    OP2_RD2   = 2'd1,
    OP2_ZERO  = 2'd2,
    OP2_ZERO3 = 2'd3
  } op2_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_ASR);
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// Register file: NREGS x WIDTH, R0 hard-wired to zero, two combinational read ports, one write port.
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: a same-cycle read sees the old contents.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/datapath_core.sv
// datapath_core: WIDTH-bit register file, operand muxes, ALU/shifter FSM and PC/LR unit.
// Define DATAPATH_BARREL_SHIFT_EN to execute shifts combinationally in a single cycle.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               NREGS    = 8,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           SysBusIn,
  output logic [WIDTH-1:0]           SysBusOut,
  input  logic                       WdSel,
  input  logic                       RegWe,
  input  logic [$clog2(NREGS)-1:0]   Rw,
  input  logic [$clog2(NREGS)-1:0]   Rs1,
  input  logic [$clog2(NREGS)-1:0]   Rs2,
  input  logic [WIDTH-1:0]           Imm,
  input  logic                       Op1Sel,
  input  logic [1:0]                 Op2Sel,
  input  logic [3:0]                 AluOp,
  input  logic [$clog2(WIDTH)-1:0]   ShAmt,
  input  logic                       CIn,
  input  logic                       Start,
  output logic                       Busy,
  output logic                       Done,
  output logic [WIDTH-1:0]           Result,
  output logic                       Z,
  output logic                       N,
  output logic                       C,
  output logic                       V,
  input  logic [2:0]                 PcSel,
  input  logic                       PcWe,
  input  logic                       LrSel,
  input  logic                       LrWe,
  output logic [WIDTH-1:0]           Pc,
  output logic [WIDTH-1:0]           Lr
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] rd1, rd2, op_a, op_b, wr_data, pc_inc;
  logic [WIDTH-1:0] alu_res, sh_res, step_res, shreg;
  logic [WIDTH:0]   sum, diff;
  logic             alu_c, alu_v, sh_c, step_c, iter_start;
  logic [SW-1:0]    cnt;
  alu_op_t          op_q;
  state_t           state;

  assign wr_data = WdSel ? SysBusIn : Result;

  datapath_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk    (Clock),
    .rst    (Reset),
    .we     (RegWe),
    .waddr  (Rw),
    .wdata  (wr_data),
    .raddr1 (Rs1),
    .raddr2 (Rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign op_a = Op1Sel ? Pc : rd1;

  always_comb begin
    case (op2_sel_t'(Op2Sel))
      OP2_IMM: op_b = Imm;
      OP2_RD2: op_b = rd2;
      default: op_b = '0;
    endcase
  end

`ifdef DATAPATH_BARREL_SHIFT_EN
  logic [WIDTH:0] shl_ext, shr_ext, asr_ext;

  // Extend by one bit so the last bit shifted out lands in the guard position.
  always_comb begin
    shl_ext = {1'b0, op_a} << ShAmt;
    shr_ext = {op_a, 1'b0} >> ShAmt;
    asr_ext = $signed({op_a, 1'b0}) >>> ShAmt;
    case (alu_op_t'(AluOp))
      ALU_SHL: begin sh_res = shl_ext[WIDTH-1:0]; sh_c = shl_ext[WIDTH]; end
      ALU_SHR: begin sh_res = shr_ext[WIDTH:1];   sh_c = shr_ext[0];     end
      default: begin sh_res = asr_ext[WIDTH:1];   sh_c = asr_ext[0];     end
    endcase
  end

  assign iter_start = 1'b0;
`else
  // Only zero-distance shifts complete in IDLE; the rest go through SHIFT.
  assign sh_res     = op_a;
  assign sh_c       = 1'b0;
  assign iter_start = is_shift(AluOp) && (ShAmt != '0);
`endif

  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, CIn};
    diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_t'(AluOp))
      ALU_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_NOT:   alu_res = ~op_a;
      ALU_NAND:  alu_res = ~(op_a & op_b);
      ALU_NOR:   alu_res = ~(op_a | op_b);
      ALU_SHL, ALU_SHR, ALU_ASR: begin
        alu_res = sh_res;
        alu_c   = sh_c;
      end
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    step_res = shreg;
    step_c   = 1'b0;
    case (op_q)
      ALU_SHL: begin step_res = {shreg[WIDTH-2:0], 1'b0};         step_c = shreg[WIDTH-1]; end
      ALU_SHR: begin step_res = {1'b0, shreg[WIDTH-1:1]};         step_c = shreg[0];       end
      default: begin step_res = {shreg[WIDTH-1], shreg[WIDTH-1:1]}; step_c = shreg[0];     end
    endcase
  end

  // Result and flags only change on completion, so they hold between operations.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      op_q   <= ALU_ADD;
      Result <= '0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            op_q  <= alu_op_t'(AluOp);
            shreg <= op_a;
            cnt   <= ShAmt;
            if (iter_start) begin
              state <= ST_SHIFT;
            end else begin
              Result <= alu_res;
              Z      <= (alu_res == '0);
              N      <= alu_res[WIDTH-1];
              C      <= alu_c;
              V      <= alu_v;
              state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          shreg <= step_res;
          cnt   <= cnt - 1'b1;
          if (cnt == SW'(1)) begin
            Result <= step_res;
            Z      <= (step_res == '0);
            N      <= step_res[WIDTH-1];
            C      <= step_c;
            V      <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state == ST_SHIFT);
  assign Done      = (state == ST_DONE);
  assign SysBusOut = Result;
  assign pc_inc    = Pc + 1'b1;

  // LR captures the pre-update PC+1, so a call can update PC and LR on one edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Pc <= PC_RESET;
      Lr <= '0;
    end else begin
      if (PcWe) begin
        case (pc_sel_t'(PcSel))
          PC_INC:    Pc <= pc_inc;
          PC_RESULT: Pc <= Result;
          PC_BUS:    Pc <= SysBusIn;
          PC_LR:     Pc <= Lr;
          default:   Pc <= Pc;
        endcase
      end
      if (LrWe) Lr <= LrSel ? Result : pc_inc;
    end
  end

endmodule
